// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring radix-2 unsigned divider
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             zero_hold;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic             last_step;

    // One restoring step: the borrow bit of the WIDTH+1-bit difference decides the quotient bit.
    always_comb begin
        shifted   = {rem, dvd[WIDTH-1]};
        diff      = shifted - {1'b0, dsr};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        last_step = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor spends two cycles in DONE; zero_hold masks valid in the first one.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid = ~zero_hold;
                if (!zero_hold) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            zero_hold   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd       <= dividend;
                        dsr       <= divisor;
                        rem       <= '0;
                        quo       <= '0;
                        count     <= '0;
                        zero_hold <= (divisor == '0);
                    end
                end
                RUN: begin
                    dvd   <= dvd << 1;
                    rem   <= rem_next;
                    quo   <= {quo[WIDTH-2:0], q_bit};
                    count <= count + CW'(1);
                    if (last_step) begin
                        quotient    <= {quo[WIDTH-2:0], q_bit};
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (zero_hold) begin
                        zero_hold   <= 1'b0;
                        quotient    <= '1;
                        remainder   <= dvd;
                        div_by_zero <= 1'b1;
                    end
                end
                default: begin
                    zero_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed and random self-checking bench for seq_div
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

    seq_div #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a division on the next edge, then wait for valid; lat counts edges after acceptance.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        int lat;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check({tag, " busy"}, 64'(ready), 64'd0);
        lat = 0;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
        @(negedge clk);
        check({tag, " valid drop"}, 64'(valid), 64'd0);
        check({tag, " ready back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        int lat;
        int nvalid;
        int nbusy;
        logic [31:0] a;
        logic [31:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 64'(ready), 64'd1);
        check("reset valid", 64'(valid), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        check("reset div_by_zero", 64'(div_by_zero), 64'd0);

        do_div("100/7", 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);
        do_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_div("ffffffff/ffffffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'd1, 32'd0, 1'b0);
        do_div("5/0", 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        do_div("9/3", 32'd9, 32'd3, 32, 32'd3, 32'd0, 1'b0);
        do_div("1/0", 32'd1, 32'd0, 1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        do_div("7/9", 32'd7, 32'd9, 32, 32'd0, 32'd7, 1'b0);
        do_div("80000000/3", 32'h8000_0000, 32'd3, 32, 32'h2AAA_AAAA, 32'd2, 1'b0);

        // start with new operands pulsed while busy must be ignored
        dividend = 32'd3;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("3/10 latency", 64'(lat), 64'd32);
        check("3/10 quotient", 64'(quotient), 64'd0);
        check("3/10 remainder", 64'(remainder), 64'd3);
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("3/10 no second valid", 64'(nvalid), 64'd0);

        // reset at edge k+10 of 1000/3, with a competing start on the same edge
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd8;
        divisor  = 32'd2;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort ready", 64'(ready), 64'd1);
        check("abort valid", 64'(valid), 64'd0);
        check("abort quotient", 64'(quotient), 64'd0);
        check("abort remainder", 64'(remainder), 64'd0);
        check("abort div_by_zero", 64'(div_by_zero), 64'd0);
        nvalid = 0;
        nbusy  = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) nvalid++;
            if (!ready) nbusy++;
        end
        check("abort no valid", 64'(nvalid), 64'd0);
        check("abort start discarded", 64'(nbusy), 64'd0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'd0;
                1:       a = 32'd1;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(2, 255));
                default: b = $urandom;
            endcase
            if (b == 32'd0)
                do_div("random", a, b, 1, 32'hFFFF_FFFF, a, 1'b1);
            else
                do_div("random", a, b, 32, a / b, a % b, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
